axis_traffic_gen: RTL

AXI-Stream packet generator that drives the injection port (axis_in_*) of a router wrapper tile on the user clock. It emits packets of programmable length, destination and ID, with a programmable inter-packet gap. Payloads are self-describing (sequence number, flit index, source) so a downstream checker can detect loss, reordering and misrouting. It is the standard stimulus source for NoC sweep builds.

---
 rtl/noc_tgen_pkg.sv | 33 +++
 rtl/axis_traffic_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_tgen_pkg.sv
// Shared types and payload layout for the AXI-Stream traffic generator.
// The payload format is what downstream checkers decode, so it lives here in one place.
package noc_tgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } tgen_state_e;

  localparam int SEQ_LSB       = 16;
  localparam int SEQ_WIDTH     = 16;
  localparam int IDX_WIDTH     = 16;
  localparam int SRC_LSB       = 32;
  localparam int SRC_MAX_WIDTH = 16;
  localparam int PAYLOAD_WIDTH = SRC_LSB + SRC_MAX_WIDTH;

  // Self-describing flit: {src, seq, idx}; bits above the source field stay zero.
  function automatic logic [PAYLOAD_WIDTH-1:0] pack_payload(
    input logic [IDX_WIDTH-1:0]     idx,
    input logic [SEQ_WIDTH-1:0]     seq,
    input logic [SRC_MAX_WIDTH-1:0] src
  );
    logic [PAYLOAD_WIDTH-1:0] p;
    p                          = '0;
    p[IDX_WIDTH-1:0]           = idx;
    p[SEQ_LSB +: SEQ_WIDTH]    = seq;
    p[SRC_LSB +: SRC_MAX_WIDTH] = src;
    return p;
  endfunction

endpackage

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator: programmable length/dest/tid/gap packets with
// self-describing payloads, driving a router tile injection port.
module axis_traffic_gen
  import noc_tgen_pkg::*;
#(
  parameter int TDATA_WIDTH    = 64,
  parameter int TID_WIDTH      = 2,
  parameter int TDEST_WIDTH    = 4,
  parameter int RTR_ADDR_WIDTH = 4,
  parameter int LEN_WIDTH      = 8,
  parameter int GAP_WIDTH      = 8,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk_usr,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [TDEST_WIDTH-1:0]    cfg_dest,
  input  logic [TID_WIDTH-1:0]      cfg_tid,
  input  logic [LEN_WIDTH-1:0]      cfg_pkt_len,
  input  logic [CNT_WIDTH-1:0]      cfg_num_pkts,
  input  logic [GAP_WIDTH-1:0]      cfg_gap,
  input  logic [RTR_ADDR_WIDTH-1:0] src_address,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  output logic [TDATA_WIDTH-1:0]    axis_out_tdata,
  output logic                      axis_out_tlast,
  output logic [TID_WIDTH-1:0]      axis_out_tid,
  output logic [TDEST_WIDTH-1:0]    axis_out_tdest,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      pkt_count,
  output logic [CNT_WIDTH-1:0]      flit_count
);

  tgen_state_e               state_q, state_d;
  logic [TDEST_WIDTH-1:0]    dest_q, dest_d;
  logic [TID_WIDTH-1:0]      tid_q, tid_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [CNT_WIDTH-1:0]      num_q, num_d;
  logic [GAP_WIDTH-1:0]      gap_q, gap_d;
  logic [RTR_ADDR_WIDTH-1:0] src_q, src_d;
  logic                      stop_pend_q, stop_pend_d;
  logic [LEN_WIDTH-1:0]      idx_q, idx_d;
  logic [SEQ_WIDTH-1:0]      seq_q, seq_d;
  logic [GAP_WIDTH-1:0]      gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0]      pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0]      flit_q, flit_d;
  logic                      tvalid_q, tvalid_d;
  logic [TDATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic                      tlast_q, tlast_d;

  logic                      hs;
  logic                      load_pl;
  logic [LEN_WIDTH-1:0]      pl_idx;
  logic [SEQ_WIDTH-1:0]      pl_seq;
  logic [LEN_WIDTH-1:0]      pl_len;
  logic [RTR_ADDR_WIDTH-1:0] pl_src;
  logic [LEN_WIDTH-1:0]      eff_len;
  logic                      last_pkt;

  assign hs       = tvalid_q & axis_out_tready;
  assign eff_len  = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  assign last_pkt = (num_q != '0) && ((pkt_q + CNT_WIDTH'(1)) == num_q);

  // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    tid_d       = tid_q;
    len_d       = len_q;
    num_d       = num_q;
    gap_d       = gap_q;
    src_d       = src_q;
    stop_pend_d = stop_pend_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_d       = pkt_q;
    flit_d      = flit_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    load_pl     = 1'b0;
    pl_idx      = '0;
    pl_seq      = seq_q;
    pl_len      = len_q;
    pl_src      = src_q;

    case (state_q)
      IDLE, DONE: begin
        // start wins over a simultaneous stop, so stop_pend is simply cleared.
        if (start) begin
          state_d     = SEND;
          dest_d      = cfg_dest;
          tid_d       = cfg_tid;
          len_d       = eff_len;
          num_d       = cfg_num_pkts;
          gap_d       = cfg_gap;
          src_d       = src_address;
          stop_pend_d = 1'b0;
          idx_d       = '0;
          seq_d       = '0;
          pkt_d       = '0;
          flit_d      = '0;
          tvalid_d    = 1'b1;
          load_pl     = 1'b1;
          pl_seq      = '0;
          pl_len      = eff_len;
          pl_src      = src_address;
        end
      end

      SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (hs) begin
          flit_d = flit_q + CNT_WIDTH'(1);
          if (tlast_q) begin
            pkt_d = pkt_q + CNT_WIDTH'(1);
            seq_d = seq_q + SEQ_WIDTH'(1);
            idx_d = '0;
            if (last_pkt || stop_pend_q || stop) begin
              state_d     = DONE;
              tvalid_d    = 1'b0;
              stop_pend_d = 1'b0;
            end else if (gap_q == '0) begin
              load_pl = 1'b1;
              pl_seq  = seq_q + SEQ_WIDTH'(1);
            end else begin
              state_d   = GAP;
              tvalid_d  = 1'b0;
              gap_cnt_d = gap_q - GAP_WIDTH'(1);
            end
          end else begin
            idx_d   = idx_q + LEN_WIDTH'(1);
            load_pl = 1'b1;
            pl_idx  = idx_q + LEN_WIDTH'(1);
          end
        end
      end

      GAP: begin
        if (stop_pend_q || stop) begin
          state_d     = DONE;
          stop_pend_d = 1'b0;
        end else if (gap_cnt_q == '0) begin
          state_d  = SEND;
          tvalid_d = 1'b1;
          load_pl  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (load_pl) begin
      tdata_d = TDATA_WIDTH'(pack_payload(IDX_WIDTH'(pl_idx), pl_seq, SRC_MAX_WIDTH'(pl_src)));
      tlast_d = (pl_idx == (pl_len - LEN_WIDTH'(1)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_usr or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      tid_q       <= '0;
      len_q       <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      src_q       <= '0;
      stop_pend_q <= 1'b0;
      idx_q       <= '0;
      seq_q       <= '0;
      gap_cnt_q   <= '0;
      pkt_q       <= '0;
      flit_q      <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      tid_q       <= tid_d;
      len_q       <= len_d;
      num_q       <= num_d;
      gap_q       <= gap_d;
      src_q       <= src_d;
      stop_pend_q <= stop_pend_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_q       <= pkt_d;
      flit_q      <= flit_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
    end
  end

  assign axis_out_tvalid = tvalid_q;
  assign axis_out_tdata  = tdata_q;
  assign axis_out_tlast  = tlast_q;
  assign axis_out_tid    = tid_q;
  assign axis_out_tdest  = dest_q;
  assign busy            = (state_q == SEND) || (state_q == GAP);
  assign done            = (state_q == DONE);
  assign pkt_count       = pkt_q;
  assign flit_count      = flit_q;

endmodule
